// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: IF-stage program counter with redirect, halt/resume and
// a valid/ready fetch handshake toward instruction memory.
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   -> misaligned redirects load TRAP_VECTOR and pulse MisalignTrap
//   undefined -> misaligned redirect targets are word-aligned, MisalignTrap = 0
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        FetchReady,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        Halt,
    input  logic        Resume,
    output logic [31:0] PCResult,
    output logic        FetchValid,
    output logic        Halted,
    output logic [31:0] FetchCount,
    output logic        MisalignTrap
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_count;
    logic        r_valid;
    logic        r_halted;
    logic        r_trap;
    logic        w_fire;
    logic        w_misalign;
    logic        w_trap_nxt;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_pc_nxt;

    assign w_fire     = r_valid & FetchReady;
    assign w_misalign = |RedirectTarget[1:0];

    // Redirect destination: trap on misalignment when enabled, otherwise word-align.
    always_comb begin
        w_redirect_pc = TRAP_EN ? (w_misalign ? TRAP_VECTOR : RedirectTarget)
                                : (RedirectTarget & ~32'h3);
        w_trap_nxt    = TRAP_EN & RedirectValid & w_misalign;
        w_pc_nxt      = RedirectValid ? w_redirect_pc :
                        w_fire        ? PCAddResult   : r_pc;
    end

    // Next-state logic: BOOT lasts one cycle; Halt beats Resume while halted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = S_RUN;
            S_RUN:   w_state_nxt = Halt ? S_HALT : S_RUN;
            S_HALT:  w_state_nxt = (Resume & ~Halt) ? S_RUN : S_HALT;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    // State, PC, counter and registered status outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state  <= S_BOOT;
            r_pc     <= RESET_VECTOR;
            r_count  <= 32'd0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
            r_trap   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_count  <= r_count + {31'd0, w_fire};
            r_valid  <= (w_state_nxt == S_RUN);
            r_halted <= (w_state_nxt == S_HALT);
            r_trap   <= w_trap_nxt;
        end
    end

    assign PCResult     = r_pc;
    assign FetchValid   = r_valid;
    assign Halted       = r_halted;
    assign FetchCount   = r_count;
    assign MisalignTrap = r_trap;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer: directed and random checks of pc_fetch_sequencer against a behavioural model.
module tb_pc_fetch_sequencer;

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] PCAddResult;
    logic        FetchReady = 1'b0;
    logic        RedirectValid = 1'b0;
    logic [31:0] RedirectTarget = 32'd0;
    logic        Halt = 1'b0;
    logic        Resume = 1'b0;
    logic [31:0] PCResult;
    logic        FetchValid;
    logic        Halted;
    logic [31:0] FetchCount;
    logic        MisalignTrap;

    int n_tests = 0;
    int n_fail  = 0;

    // model: mode 0 = boot, 1 = run, 2 = halt
    logic [31:0] m_pc;
    logic [31:0] m_count;
    int          m_mode;
    bit          m_trap;

    pc_fetch_sequencer dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .FetchReady(FetchReady),
        .RedirectValid(RedirectValid), .RedirectTarget(RedirectTarget), .Halt(Halt),
        .Resume(Resume), .PCResult(PCResult), .FetchValid(FetchValid), .Halted(Halted),
        .FetchCount(FetchCount), .MisalignTrap(MisalignTrap)
    );

    always #5 Clk = ~Clk;
    assign PCAddResult = PCResult + 32'd4;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_count = 32'd0; m_mode = 0; m_trap = 1'b0;
    endtask

    task automatic drive(input bit rdy, input bit rv, input logic [31:0] tgt, input bit h, input bit r);
        bit fire;
        FetchReady = rdy; RedirectValid = rv; RedirectTarget = tgt; Halt = h; Resume = r;
        if (!Reset) model_reset();
        else begin
            fire = (m_mode == 1) && rdy;
            if (rv) m_pc = TRAP_EN ? ((tgt % 4 != 0) ? 32'h80 : tgt) : (tgt / 4) * 4;
            else if (fire) m_pc = m_pc + 32'd4;
            m_count = m_count + (fire ? 32'd1 : 32'd0);
            m_trap  = TRAP_EN && rv && (tgt % 4 != 0);
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) m_mode = h ? 2 : 1;
            else m_mode = (r && !h) ? 1 : 2;
        end
    endtask

    task automatic step(input bit rdy, input bit rv, input logic [31:0] tgt, input bit h, input bit r);
        @(negedge Clk);
        drive(rdy, rv, tgt, h, r);
        @(posedge Clk);
        #2;
    endtask

    task automatic rand_cycle();
        logic [31:0] t;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t = t & ~32'h3;
        if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
        @(negedge Clk);
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, t,
              $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    endtask

    // continuous comparison of every output against the model
    always @(posedge Clk) begin
        #1;
        cmp("pc", PCResult, m_pc);
        cmp("valid", {31'd0, FetchValid}, {31'd0, m_mode == 1});
        cmp("halted", {31'd0, Halted}, {31'd0, m_mode == 2});
        cmp("count", FetchCount, m_count);
        cmp("trap", {31'd0, MisalignTrap}, {31'd0, m_trap});
    end

    initial begin
        model_reset();
        #2 Reset = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            drive(1, 0, 0, 0, 0);
        end
        cmp("rst_pc", PCResult, 32'h0);
        cmp("rst_valid", {31'd0, FetchValid}, 32'd0);
        cmp("rst_count", FetchCount, 32'd0);
        // boot cycle then sequential fetch
        @(negedge Clk);
        Reset = 1'b1;
        drive(1, 0, 0, 0, 0);
        #1;
        cmp("boot_valid", {31'd0, FetchValid}, 32'd0);
        cmp("boot_pc", PCResult, 32'h0);
        @(posedge Clk);
        #2;
        cmp("run_pc0", PCResult, 32'h0);
        cmp("run_valid", {31'd0, FetchValid}, 32'd1);
        step(1, 0, 0, 0, 0); cmp("pc4", PCResult, 32'h4);
        step(1, 0, 0, 0, 0); cmp("pc8", PCResult, 32'h8);
        step(1, 0, 0, 0, 0); cmp("count3", FetchCount, 32'd3);
        // backpressure
        step(1, 1, 32'h10, 0, 0); cmp("pc10", PCResult, 32'h10);
        repeat (3) begin
            step(0, 0, 0, 0, 0);
            cmp("bp_pc", PCResult, 32'h10);
            cmp("bp_valid", {31'd0, FetchValid}, 32'd1);
            cmp("bp_count", FetchCount, 32'd4);
        end
        step(1, 0, 0, 0, 0); cmp("pc14", PCResult, 32'h14);
        // redirect with fire
        step(1, 1, 32'h20, 0, 0); cmp("pc20", PCResult, 32'h20);
        step(1, 1, 32'h100, 0, 0);
        cmp("pc100", PCResult, 32'h100);
        cmp("count7", FetchCount, 32'd7);
        // halt with fire, halt priority, resume
        step(1, 1, 32'h8, 0, 0);
        step(1, 0, 0, 1, 0);
        cmp("halt_pc", PCResult, 32'hC);
        cmp("halt_h", {31'd0, Halted}, 32'd1);
        cmp("halt_v", {31'd0, FetchValid}, 32'd0);
        cmp("halt_cnt", FetchCount, 32'd9);
        repeat (2) begin
            step(1, 0, 0, 1, 1);
            cmp("hr_h", {31'd0, Halted}, 32'd1);
        end
        step(1, 0, 0, 0, 1);
        cmp("res_v", {31'd0, FetchValid}, 32'd1);
        cmp("res_pc", PCResult, 32'hC);
        // misaligned redirect
        step(1, 1, 32'h102, 0, 0);
        cmp("mis_pc", PCResult, TRAP_EN ? 32'h80 : 32'h100);
        cmp("mis_trap", {31'd0, MisalignTrap}, {31'd0, TRAP_EN});
        step(0, 0, 0, 0, 0);
        cmp("mis_trap_end", {31'd0, MisalignTrap}, 32'd0);
        // wrap
        step(1, 1, 32'hFFFF_FFFC, 0, 0); cmp("pc_top", PCResult, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0); cmp("pc_wrap", PCResult, 32'h0);
        // random phase
        repeat (3000) rand_cycle();
        // asynchronous reset mid-cycle
        @(posedge Clk);
        #3 Reset = 1'b0;
        model_reset();
        #1;
        cmp("arst_pc", PCResult, 32'h0);
        cmp("arst_valid", {31'd0, FetchValid}, 32'd0);
        cmp("arst_halted", {31'd0, Halted}, 32'd0);
        cmp("arst_count", FetchCount, 32'd0);
        @(negedge Clk);
        drive(1, 0, 0, 0, 0);
        @(negedge Clk);
        Reset = 1'b1;
        drive(1, 0, 0, 0, 0);
        repeat (300) rand_cycle();
        @(posedge Clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
